// File: rtl/mem_access_pkg.sv
// Shared types for the byte-serial load/store engine: FSM encoding,
// request size codes and the load-result extension helper.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_STROBE,
    WR_NEXT
  } state_t;

  localparam int unsigned SIZE_BYTE = 0;
  localparam int unsigned SIZE_HALF = 1;
  localparam int unsigned SIZE_LONG = 3;
  localparam int unsigned SIZE_QUAD = 7;

  // raw holds (size+1) bytes right-justified; everything above is masked
  // to zero or filled with the top bit of the slice.
  function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                              input logic [2:0]  size,
                                              input logic        sgn);
    logic [63:0] mask;
    logic        msb;
    mask = ~64'd0 >> {~size, 3'b000};
    msb  = raw[{size, 3'b111}];
    return (raw & mask) | ((sgn && msb) ? ~mask : 64'd0);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Load/store engine: splits a 1..DATA_BYTES byte request into big-endian
// single-byte memory accesses, honouring mem_ready wait states.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int addr_width   = 9,
  parameter int DATA_BYTES   = 4,
  parameter int READ_LATENCY = 2,
  localparam int DW = 8 * DATA_BYTES,
  localparam int SW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [SW-1:0]         req_size,
  input  logic                  req_signed,
  input  logic [addr_width-1:0] req_addr,
  input  logic [DW-1:0]         req_wdata,
  output logic                  resp_valid,
  output logic [DW-1:0]         resp_rdata,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out,
  output logic                  mem_write,
  input  logic                  mem_ready
);

  localparam int CW = $clog2(READ_LATENCY + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] left, size_q;
  logic          sgn_q;
  logic [DW-1:0] wbuf, acc;
  logic [DW-1:0] acc_next;
  logic [SW-1:0] left_m1;

  assign req_ready = (state == IDLE) && !reset;
  assign acc_next  = (acc << 8) | DW'(mem_data_out);
  assign left_m1   = left - SW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      left        <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      wbuf        <= '0;
      acc         <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      mem_raddr   <= '0;
      mem_waddr   <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          size_q <= req_size;
          left   <= req_size;
          sgn_q  <= req_signed;
          wbuf   <= req_wdata;
          acc    <= '0;
          if (req_write) begin
            mem_waddr   <= req_addr;
            mem_data_in <= req_wdata[{req_size, 3'b000} +: 8];
            state       <= WR_STROBE;
          end else begin
            mem_raddr <= req_addr;
            cnt       <= CW'(READ_LATENCY);
            state     <= RD_WAIT;
          end
        end
        // Count down to 1, then keep retrying the capture until mem_ready.
        RD_WAIT: if (cnt != CW'(1)) begin
          cnt <= cnt - CW'(1);
        end else if (mem_ready) begin
          acc <= acc_next;
          if (left != '0) begin
            left      <= left_m1;
            mem_raddr <= mem_raddr + addr_width'(1);
            cnt       <= CW'(READ_LATENCY);
          end else begin
            resp_rdata <= DW'(extend_load(64'(acc_next), 3'(size_q), sgn_q));
            resp_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        WR_STROBE: if (mem_ready) begin
          mem_write <= 1'b1;
          state     <= WR_NEXT;
        end
        WR_NEXT: begin
          mem_write <= 1'b0;
          if (left != '0) begin
            left        <= left_m1;
            mem_waddr   <= mem_waddr + addr_width'(1);
            mem_data_in <= wbuf[{left_m1, 3'b000} +: 8];
            state       <= WR_STROBE;
          end else begin
            resp_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: 32-bit engine with wait-state injection plus a 64-bit
// instance, each against a byte memory with one registered read stage.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // backdoor preload shared by both memories
  logic       bd_we;
  logic [8:0] bd_addr;
  logic [7:0] bd_data;

  // 32-bit instance
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [8:0]  mem_raddr, mem_waddr;
  logic [7:0]  mem_data_in, mem_data_out;
  logic        mem_write, mem_ready;

  mem_access_unit #(.addr_width(9), .DATA_BYTES(4), .READ_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_write(mem_write), .mem_ready(mem_ready)
  );

  logic [7:0] mem [0:511];
  logic [7:0] rd_q;
  assign mem_data_out = rd_q;
  always @(posedge clk) begin
    rd_q <= mem[mem_raddr];
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_write) mem[mem_waddr] <= mem_data_in;
  end

  // 64-bit instance
  logic        b_req_valid, b_req_ready, b_req_write, b_req_signed;
  logic [2:0]  b_req_size;
  logic [8:0]  b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_resp_valid;
  logic [63:0] b_resp_rdata;
  logic [8:0]  b_mem_raddr, b_mem_waddr;
  logic [7:0]  b_mem_data_in, b_mem_data_out;
  logic        b_mem_write, b_mem_ready;

  mem_access_unit #(.addr_width(9), .DATA_BYTES(8), .READ_LATENCY(2)) dut8 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .mem_raddr(b_mem_raddr), .mem_waddr(b_mem_waddr), .mem_data_in(b_mem_data_in),
    .mem_data_out(b_mem_data_out), .mem_write(b_mem_write), .mem_ready(b_mem_ready)
  );

  logic [7:0] mem8 [0:511];
  logic [7:0] rd8_q;
  assign b_mem_data_out = rd8_q;
  always @(posedge clk) begin
    rd8_q <= mem8[b_mem_raddr];
    if (bd_we) mem8[bd_addr] <= bd_data;
    else if (b_mem_write) mem8[b_mem_waddr] <= b_mem_data_in;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [8:0] ad, input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = ad + 9'(i);
      bd_data = bytes[8*(n-1-i) +: 8];
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // lat counts edges after the accept edge until resp_valid is seen;
  // mem_ready is held low for edges st_at .. st_at+st_len-1.
  task automatic run_a(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [8:0] ad, input logic [31:0] wd,
                       input int st_at, input int st_len,
                       output int lat, output logic rdy);
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    rdy = 1'b0;
    while (lat < 100) begin
      mem_ready = !((lat + 1) >= st_at && (lat + 1) < st_at + st_len);
      @(posedge clk);
      lat++;
      #1;
      if (resp_valid) begin
        rdy = req_ready;
        break;
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic run_b(input logic [2:0] sz, input logic sg, input logic [8:0] ad,
                       output int lat);
    @(negedge clk);
    b_req_write = 1'b0; b_req_size = sz; b_req_signed = sg;
    b_req_addr = ad; b_req_wdata = '0; b_req_valid = 1'b1;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (b_resp_valid) break;
    end
  endtask

  initial begin
    int   lat;
    logic rdy;
    logic rv_seen;

    reset = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0;
    req_size = '0; req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_signed = 1'b0;
    b_req_size = '0; b_req_addr = '0; b_req_wdata = '0; b_mem_ready = 1'b1;

    #12;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_outs", {resp_valid, mem_write, 4'd0, resp_rdata},
          {1'b0, 1'b0, 4'd0, 32'd0});
    check("rst_addr_data", {mem_raddr, mem_waddr, mem_data_in}, 26'd0);

    poke(9'h010, 64'h12345678, 4);
    poke(9'h020, 64'h80, 1);
    poke(9'h030, 64'h8102, 2);
    poke(9'h1FE, 64'h00_00, 2);
    poke(9'h000, 64'h00, 1);
    poke(9'h050, 64'hDEADBEEF, 4);
    poke(9'h040, 64'h00000000, 4);
    poke(9'h060, 64'h0102030405060708, 8);
    poke(9'h070, 64'hF0000001, 4);

    @(negedge clk);
    reset = 1'b0;
    #1 check("req_ready_after_rst", 64'(req_ready), 64'd1);

    run_a(1'b0, 2'd3, 1'b0, 9'h010, 32'h0, 0, 0, lat, rdy);
    check("ld_long_data", 64'(resp_rdata), 64'h12345678);
    check("ld_long_lat", 64'(lat), 64'd8);
    check("ld_ready_with_resp", 64'(rdy), 64'd1);

    run_a(1'b0, 2'd0, 1'b1, 9'h020, 32'h0, 0, 0, lat, rdy);
    check("ld_byte_signed", 64'(resp_rdata), 64'hFFFFFF80);
    check("ld_byte_lat", 64'(lat), 64'd2);
    run_a(1'b0, 2'd0, 1'b0, 9'h020, 32'h0, 0, 0, lat, rdy);
    check("ld_byte_unsigned", 64'(resp_rdata), 64'h00000080);
    run_a(1'b0, 2'd1, 1'b1, 9'h030, 32'h0, 0, 0, lat, rdy);
    check("ld_half_signed", 64'(resp_rdata), 64'hFFFF8102);

    run_a(1'b1, 2'd1, 1'b1, 9'h1FF, 32'h0000ABCD, 0, 0, lat, rdy);
    check("st_wrap_lat", 64'(lat), 64'd4);
    check("st_wrap_hi", 64'(mem[9'h1FF]), 64'hAB);
    check("st_wrap_lo", 64'(mem[9'h000]), 64'hCD);
    check("st_neighbour", 64'(mem[9'h1FE]), 64'h00);
    check("st_keeps_rdata", 64'(resp_rdata), 64'hFFFF8102);

    run_a(1'b0, 2'd3, 1'b0, 9'h050, 32'h0, 4, 3, lat, rdy);
    check("ld_stall_data", 64'(resp_rdata), 64'hDEADBEEF);
    check("ld_stall_lat", 64'(lat), 64'd11);

    // reset in the middle of the third byte's write strobe
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd3; req_addr = 9'h040;
    req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("rst_mid_pulse_on", 64'(mem_write), 64'd1);
    check("rst_mid_addr", 64'(mem_waddr), 64'h042);
    reset = 1'b1;
    #1;
    check("rst_mid_write_drop", 64'(mem_write), 64'd0);
    check("rst_mid_ready_low", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rv_seen = rv_seen | resp_valid | mem_write;
    end
    check("rst_mid_no_resp", 64'(rv_seen), 64'd0);
    check("rst_mid_written", {48'd0, mem[9'h040], mem[9'h041]}, 64'h1122);
    check("rst_mid_untouched", {48'd0, mem[9'h042], mem[9'h043]}, 64'h0000);
    check("rst_mid_ready_after", 64'(req_ready), 64'd1);

    run_b(3'd7, 1'b0, 9'h060, lat);
    check("quad_data", b_resp_rdata, 64'h0102030405060708);
    check("quad_lat", 64'(lat), 64'd16);
    run_b(3'd3, 1'b1, 9'h070, lat);
    check("quad_long_signed", b_resp_rdata, 64'hFFFFFFFFF0000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
